// File: rtl/shake_arb_if.sv
// Handshake bundle between two hash requesters, the arbiter and one SHAKE core.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface shake_arb_if #(
  parameter int W = 64
);
  logic [1:0]          req_valid;
  logic [1:0][1:0]     req_mode;
  logic [1:0][31:0]    req_output_size;
  logic [1:0][W-1:0]   req_data;
  logic [1:0]          req_data_valid;
  logic [1:0]          req_data_last;
  logic [1:0]          req_data_ready;
  logic [1:0]          req_grant;
  logic [W-1:0]        req_out_data;
  logic [1:0]          req_out_valid;
  logic [1:0]          req_out_ready;
  logic                core_start;
  logic [1:0]          core_mode;
  logic [31:0]         core_output_size;
  logic [W-1:0]        core_data;
  logic                core_data_valid;
  logic                core_data_last;
  logic                core_data_ready;
  logic [W-1:0]        core_out_data;
  logic                core_out_valid;
  logic                core_out_ready;

  modport slave (
    input  req_valid, req_mode, req_output_size, req_data, req_data_valid, req_data_last,
           req_out_ready, core_data_ready, core_out_data, core_out_valid,
    output req_data_ready, req_grant, req_out_data, req_out_valid, core_start, core_mode,
           core_output_size, core_data, core_data_valid, core_data_last, core_out_ready
  );

  modport master (
    output req_valid, req_mode, req_output_size, req_data, req_data_valid, req_data_last,
           req_out_ready, core_data_ready, core_out_data, core_out_valid,
    input  req_data_ready, req_grant, req_out_data, req_out_valid, core_start, core_mode,
           core_output_size, core_data, core_data_valid, core_data_last, core_out_ready
  );
endinterface

// File: rtl/shake_request_arbiter.sv
// Round-robin arbiter sharing one SHAKE core between two requesters; an operation
// owns the core from grant through absorb and the full squeeze before release.
module shake_request_arbiter #(
  parameter int W = 64
) (
  input  logic      clk,
  input  logic      rst,
  shake_arb_if.slave bus
);
  localparam int LW = $clog2(W);

  typedef enum logic [1:0] {IDLE, START, ABSORB, SQUEEZE} state_t;

  state_t      state;
  logic [1:0]  grant;
  logic        last_grant;
  logic [31:0] cnt;
  logic [1:0]  mode;
  logic [31:0] size;
  logic        start;
  logic        win;
  logic        abs_xfer, abs_last, sq_xfer;

  // 33-bit sum keeps size 0xFFFFFFFF from wrapping to a tiny word count
  function automatic logic [31:0] words(input logic [31:0] s);
    logic [32:0] sum;
    sum = {1'b0, s} + 33'(W - 1);
    return 32'(sum >> LW);
  endfunction

  always_comb begin
    win = bus.req_valid[1];
    if (bus.req_valid[0] && bus.req_valid[1]) win = ~last_grant;
  end

  // last_grant doubles as the index of the owning requester while granted
  assign abs_xfer = (state == ABSORB) & bus.req_data_valid[last_grant] & bus.core_data_ready;
  assign abs_last = bus.req_data_last[last_grant];
  assign sq_xfer  = (state == SQUEEZE) & bus.core_out_valid & bus.req_out_ready[last_grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      cnt        <= '0;
      mode       <= '0;
      size       <= '0;
      start      <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: if (|bus.req_valid) begin
          state      <= START;
          grant      <= win ? 2'b10 : 2'b01;
          last_grant <= win;
          mode       <= bus.req_mode[win];
          size       <= bus.req_output_size[win];
          cnt        <= words(bus.req_output_size[win]);
          start      <= 1'b1;
        end
        START: state <= ABSORB;
        ABSORB: if (abs_xfer && abs_last) begin
          if (cnt == '0) begin
            state <= IDLE;
            grant <= 2'b00;
          end else begin
            state <= SQUEEZE;
          end
        end
        SQUEEZE: if (sq_xfer) begin
          cnt <= cnt - 32'd1;
          if (cnt == 32'd1) begin
            state <= IDLE;
            grant <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_grant        = grant;
  assign bus.core_start       = start;
  assign bus.core_mode        = mode;
  assign bus.core_output_size = size;
  assign bus.core_data        = bus.req_data[last_grant];
  assign bus.req_out_data     = bus.core_out_data;

  always_comb begin
    bus.core_data_valid = 1'b0;
    bus.core_data_last  = 1'b0;
    bus.req_data_ready  = 2'b00;
    bus.req_out_valid   = 2'b00;
    bus.core_out_ready  = 1'b0;
    if (state == ABSORB) begin
      bus.core_data_valid            = bus.req_data_valid[last_grant];
      bus.core_data_last             = bus.req_data_last[last_grant];
      bus.req_data_ready[last_grant] = bus.core_data_ready;
    end
    if (state == SQUEEZE) begin
      bus.req_out_valid[last_grant] = bus.core_out_valid;
      bus.core_out_ready            = bus.req_out_ready[last_grant];
    end
  end
endmodule

// File: tb/tb_shake_request_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, absorb words and squeeze words;
// a negedge monitor pops and compares whenever the arbiter presents a transfer.
module tb_shake_request_arbiter;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shake_arb_if #(.W(W)) bus();
  shake_request_arbiter #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          r;
    logic [1:0]  mode;
    logic [31:0] size;
  } op_t;

  int checks = 0;
  int errors = 0;
  op_t        exp_op[$];
  logic [W:0] exp_abs0[$], exp_abs1[$];
  logic [W-1:0] exp_sq0[$], exp_sq1[$];
  logic bp_en = 1'b0;

  task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input int r, input logic [1:0] mode, input logic [31:0] size,
                           input int nw, input logic [W-1:0] base, input int nsq);
    op_t o;
    o.r = r; o.mode = mode; o.size = size;
    exp_op.push_back(o);
    for (int i = 0; i < nw; i++) begin
      if (r == 0) exp_abs0.push_back({1'(i == nw - 1), base + W'(i)});
      else        exp_abs1.push_back({1'(i == nw - 1), base + W'(i)});
    end
    for (int i = 0; i < nsq; i++) begin
      if (r == 0) exp_sq0.push_back(base ^ W'(i));
      else        exp_sq1.push_back(base ^ W'(i));
    end
  endtask

  task automatic wait_grant(input int r, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.req_grant[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_timeout", 128'(bus.req_grant), 128'(1 << r));
  endtask

  task automatic run_req(input int r, input logic [1:0] mode, input logic [31:0] size,
                         input int nw, input logic [W-1:0] base);
    bit ok;
    bus.req_mode[r]        = mode;
    bus.req_output_size[r] = size;
    bus.req_data[r]        = base;
    bus.req_data_last[r]   = (nw == 1);
    bus.req_data_valid[r]  = 1'b1;
    bus.req_valid[r]       = 1'b1;
    wait_grant(r, ok);
    step();
    bus.req_valid[r] = 1'b0;
    for (int i = 0; i < nw && ok; i++) begin
      bus.req_data[r]       = base + W'(i);
      bus.req_data_last[r]  = (i == nw - 1);
      bus.req_data_valid[r] = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (bus.req_data_ready[r]) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) check("absorb_timeout", 128'(bus.req_data_ready), 128'(1 << r));
      step();
    end
    bus.req_data_valid[r] = 1'b0;
    bus.req_data_last[r]  = 1'b0;
    bus.req_valid[r]      = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!bus.req_grant[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("release_timeout", 128'(bus.req_grant[r]), 128'(0));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_grant", 128'(bus.req_grant), 128'(0));
    check("async_rst_outs", 128'({bus.core_start, bus.req_data_ready, bus.req_out_valid,
                                  bus.core_data_valid, bus.core_out_ready}), 128'(0));
    bus.req_valid = 2'b00; bus.req_data_valid = 2'b00; bus.req_data_last = 2'b00;
    exp_op.delete(); exp_abs0.delete(); exp_abs1.delete(); exp_sq0.delete(); exp_sq1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Core model: latches size at core_start, first absorb word is the squeeze seed,
  // and after the last absorb word emits ceil(size/64) words seed ^ index.
  initial begin
    logic [W-1:0] base, ad;
    logic [31:0]  osz, sz;
    logic st, ax, al, sx, fresh;
    longint rem;
    int idx, cyc;
    base = '0; osz = '0; rem = 0; idx = 0; cyc = 0; fresh = 1'b1;
    bus.core_data_ready = 1'b0;
    bus.core_out_valid  = 1'b0;
    bus.core_out_data   = '0;
    forever begin
      @(negedge clk);
      st = bus.core_start; sz = bus.core_output_size;
      ax = bus.core_data_valid & bus.core_data_ready;
      al = bus.core_data_last; ad = bus.core_data;
      sx = bus.core_out_valid & bus.core_out_ready;
      step();
      cyc++;
      if (rst) begin
        rem = 0; fresh = 1'b1;
      end else begin
        if (st) begin osz = sz; fresh = 1'b1; end
        if (ax) begin
          if (fresh) base = ad;
          fresh = 1'b0;
          if (al) begin rem = (longint'(osz) + 63) / 64; idx = 0; end
        end
        if (sx) begin idx++; rem--; end
      end
      bus.core_out_valid  = (rem > 0);
      bus.core_out_data   = base ^ W'(idx);
      bus.core_data_ready = (cyc % 3) != 2;
    end
  end

  // Squeeze consumer ready: constant 1, or the 1,0,0,1 pattern under back-pressure
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001; ph = 0;
    bus.req_out_ready = 2'b11;
    forever begin
      step();
      if (bp_en) begin
        bus.req_out_ready = {2{pat[ph]}};
        ph = (ph + 1) % 4;
      end else begin
        bus.req_out_ready = 2'b11;
      end
    end
  end

  // Monitor
  initial begin
    logic [1:0] prev_grant;
    op_t o;
    logic [W:0] ea;
    logic [W-1:0] es;
    int r;
    prev_grant = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.req_grant != 2'b00 && prev_grant == 2'b00) begin
          if (exp_op.size() == 0) check("unexpected_grant", 128'(bus.req_grant), 128'(0));
          else begin
            o = exp_op.pop_front();
            check("grant_owner", 128'(bus.req_grant), 128'(o.r == 1 ? 2'b10 : 2'b01));
            check("core_start_at_grant", 128'(bus.core_start), 128'(1));
            check("core_mode", 128'(bus.core_mode), 128'(o.mode));
            check("core_output_size", 128'(bus.core_output_size), 128'(o.size));
          end
        end else if (bus.core_start) begin
          check("stray_core_start", 128'(bus.core_start), 128'(0));
        end
        if (bus.req_grant == 2'b00 || bus.core_start)
          check("idle_handshake", 128'({bus.req_data_ready, bus.req_out_valid,
                                        bus.core_data_valid, bus.core_out_ready}), 128'(0));
        if (bus.core_data_valid && bus.core_data_ready) begin
          r = bus.req_grant[1] ? 1 : 0;
          check("absorb_other_ready", 128'(bus.req_data_ready[1-r]), 128'(0));
          if ((r == 0 ? exp_abs0.size() : exp_abs1.size()) == 0)
            check("unexpected_absorb", 128'({bus.core_data_last, bus.core_data}), 128'(0));
          else begin
            ea = (r == 0) ? exp_abs0.pop_front() : exp_abs1.pop_front();
            check("absorb_word", 128'({bus.core_data_last, bus.core_data}), 128'(ea));
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (bus.req_out_valid[i] && bus.req_out_ready[i]) begin
            check("squeeze_other_valid", 128'(bus.req_out_valid[1-i]), 128'(0));
            if ((i == 0 ? exp_sq0.size() : exp_sq1.size()) == 0)
              check("unexpected_squeeze", 128'(bus.req_out_data), 128'(0));
            else begin
              es = (i == 0) ? exp_sq0.pop_front() : exp_sq1.pop_front();
              check("squeeze_word", 128'(bus.req_out_data), 128'(es));
            end
          end
        end
      end
      prev_grant = rst ? 2'b00 : bus.req_grant;
    end
  end

  initial begin
    bit ok;
    bus.req_valid = 2'b00; bus.req_mode = '0; bus.req_output_size = '0;
    bus.req_data = '0; bus.req_data_valid = 2'b00; bus.req_data_last = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_grant", 128'(bus.req_grant), 128'(0));
    check("rst_core_regs", 128'({bus.core_start, bus.core_mode, bus.core_output_size}), 128'(0));
    check("rst_handshake", 128'({bus.req_data_ready, bus.req_out_valid,
                                 bus.core_data_valid, bus.core_out_ready}), 128'(0));
    check("rst_last_grant", 128'(dut.last_grant), 128'(1));
    check("rst_cnt", 128'(dut.cnt), 128'(0));
    step();
    rst = 1'b0;
    step();

    // Tie after reset: requester 0 first, then round-robin 0,1,0,1
    for (int rep = 0; rep < 2; rep++) begin
      expect_op(0, 2'b01, 32'd64, 2, 64'hA000 + 64'(rep * 16), 1);
      expect_op(1, 2'b10, 32'd64, 1, 64'hB000 + 64'(rep * 16), 1);
      fork
        run_req(0, 2'b01, 32'd64, 2, 64'hA000 + 64'(rep * 16));
        run_req(1, 2'b10, 32'd64, 1, 64'hB000 + 64'(rep * 16));
      join
      step();
    end

    // Single request: 3 absorb words, 256 bits -> 4 squeeze words
    expect_op(0, 2'b00, 32'd256, 3, 64'h1234_5678_0000_0000, 4);
    run_req(0, 2'b00, 32'd256, 3, 64'h1234_5678_0000_0000);

    // Size 65 -> 2 words; size 0 -> none
    expect_op(1, 2'b11, 32'd65, 2, 64'hC0DE_0000, 2);
    run_req(1, 2'b11, 32'd65, 2, 64'hC0DE_0000);
    expect_op(0, 2'b01, 32'd0, 2, 64'hD00D_0000, 0);
    run_req(0, 2'b01, 32'd0, 2, 64'hD00D_0000);

    // Squeeze back-pressure
    bp_en = 1'b1;
    expect_op(1, 2'b00, 32'd256, 1, 64'hFEED_0000, 4);
    run_req(1, 2'b00, 32'd256, 1, 64'hFEED_0000);
    bp_en = 1'b0;
    step();

    // Maximum size: word count must load without wrapping, then abandon by reset
    expect_op(1, 2'b11, 32'hFFFF_FFFF, 0, 64'h0, 0);
    bus.req_mode[1] = 2'b11; bus.req_output_size[1] = 32'hFFFF_FFFF; bus.req_valid[1] = 1'b1;
    wait_grant(1, ok);
    check("cnt_max_size", 128'(dut.cnt), 128'(32'h0400_0000));
    assert (dut.cnt == 32'h0400_0000);
    bus.req_valid[1] = 1'b0;
    step();
    pulse_reset();

    // Reset in the middle of a 5-word absorb
    expect_op(0, 2'b01, 32'd320, 5, 64'h5000, 5);
    bus.req_mode[0] = 2'b01; bus.req_output_size[0] = 32'd320;
    bus.req_data[0] = 64'h5000; bus.req_data_valid[0] = 1'b1; bus.req_valid[0] = 1'b1;
    wait_grant(0, ok);
    step();
    bus.req_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.req_data_ready[0]) begin
        step();
        bus.req_data[0] = bus.req_data[0] + 64'd1;
      end else step();
    end
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_start_after_rst", 128'({bus.core_start, bus.req_grant}), 128'(0));
    end

    // Fresh operation after the abandoned one
    step();
    expect_op(1, 2'b10, 32'd128, 1, 64'h7777, 2);
    run_req(1, 2'b10, 32'd128, 1, 64'h7777);
    repeat (4) step();

    check("left_ops", 128'(exp_op.size()), 128'(0));
    check("left_absorb", 128'(exp_abs0.size() + exp_abs1.size()), 128'(0));
    check("left_squeeze", 128'(exp_sq0.size() + exp_sq1.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
